// File: rtl/mem_mapper_ws_pkg.sv
// Shared types and default region map for the wait-state memory mapper.
// Regions are packed with region i at slice i; index 0 has the highest priority.
package mem_mapper_ws_pkg;

  typedef enum logic [1:0] {
    MMW_IDLE = 2'd0,
    MMW_WAIT = 2'd1,
    MMW_DONE = 2'd2,
    MMW_ERR  = 2'd3
  } mmw_state_e;

  localparam int MMW_AW   = 16;
  localparam int MMW_DW   = 16;
  localparam int MMW_NREG = 5;

  localparam logic [MMW_DW-1:0] MMW_ERR_PATTERN = 16'hFFFF;

  // Default map: ROM, RAM, UART, INT, GPIO in regions 0..4.
  localparam logic [MMW_NREG*MMW_AW-1:0] MMW_DEF_BASE =
    {16'hFFF0, 16'hFFE8, 16'hFFE0, 16'h2000, 16'h0000};
  localparam logic [MMW_NREG*MMW_AW-1:0] MMW_DEF_LIMIT =
    {16'hFFF3, 16'hFFEF, 16'hFFE7, 16'h5FFF, 16'h1FFF};
  localparam logic [MMW_NREG*4-1:0] MMW_DEF_WAIT =
    {4'd1, 4'd5, 4'd1, 4'd2, 4'd0};
  localparam logic [MMW_NREG-1:0] MMW_DEF_ACK = 5'b00100;

  function automatic logic mmw_req(input logic rdn, input logic wr0n, input logic wr1n);
    return ~rdn | ~wr0n | ~wr1n;
  endfunction

  function automatic logic mmw_proto_err(input logic rdn, input logic wr0n, input logic wr1n);
    return ~rdn & (~wr0n | ~wr1n);
  endfunction

endpackage

// File: rtl/mem_mapper_ws_if.sv
// CPU-side and device-side bus of the mapper. The master modport belongs to the
// CPU/device environment, the slave modport to the mapper itself.
interface mem_mapper_ws_if #(
  parameter int AW   = 16,
  parameter int DW   = 16,
  parameter int NREG = 5
);
  logic [AW-1:0]      ADDR;
  logic               RDN;
  logic               WR0N;
  logic               WR1N;
  logic [DW-1:0]      CPU_DIN;
  logic               READY;
  logic [NREG*DW-1:0] DIN_DEV;
  logic [DW-1:0]      DIN_BUS;
  logic [NREG-1:0]    DEV_ACK;
  logic [NREG-1:0]    SEL;
  logic               RD_DEV;
  logic               WR_DEV;
  logic [1:0]         BE;
  logic [AW-1:0]      DEV_ADDR;
  logic               FAULT_IRQ;
  logic [AW-1:0]      FAULT_ADDR;
  logic               FAULT_CLR;

  modport master (
    output ADDR, RDN, WR0N, WR1N, DIN_DEV, DIN_BUS, DEV_ACK, FAULT_CLR,
    input  CPU_DIN, READY, SEL, RD_DEV, WR_DEV, BE, DEV_ADDR, FAULT_IRQ, FAULT_ADDR
  );

  modport slave (
    input  ADDR, RDN, WR0N, WR1N, DIN_DEV, DIN_BUS, DEV_ACK, FAULT_CLR,
    output CPU_DIN, READY, SEL, RD_DEV, WR_DEV, BE, DEV_ADDR, FAULT_IRQ, FAULT_ADDR
  );
endinterface

// File: rtl/mem_mapper_ws_region_decoder.sv
// Combinational priority decoder: the lowest-indexed region containing the
// address wins. Regions with base above limit can never match.
module mem_mapper_ws_region_decoder #(
  parameter int                   AW        = 16,
  parameter int                   NREG      = 5,
  parameter int                   IW        = 3,
  parameter logic [NREG*AW-1:0]   REG_BASE  = '0,
  parameter logic [NREG*AW-1:0]   REG_LIMIT = '0
) (
  input  logic [AW-1:0]   addr_i,
  output logic            hit_o,
  output logic [IW-1:0]   idx_o,
  output logic [NREG-1:0] onehot_o
);

  logic [NREG-1:0] match_s;

  // Isolate the lowest set match bit, then encode it.
  always_comb begin
    match_s = '0;
    idx_o   = '0;
    for (int i = 0; i < NREG; i++) begin
      match_s[i] = (addr_i >= REG_BASE[i*AW +: AW]) && (addr_i <= REG_LIMIT[i*AW +: AW]);
    end
    onehot_o = match_s & (~match_s + {{(NREG-1){1'b0}}, 1'b1});
    hit_o    = |match_s;
    for (int i = 0; i < NREG; i++) begin
      idx_o = idx_o | (onehot_o[i] ? IW'(i) : IW'(0));
    end
  end

endmodule

// File: rtl/mem_mapper_ws.sv
// Clocked memory mapper: decodes CPU accesses into regions, inserts per-region
// wait states, optionally waits for a device ack, and traps errors and timeouts.
module mem_mapper_ws
  import mem_mapper_ws_pkg::*;
#(
  parameter int                 AW        = MMW_AW,
  parameter int                 DW        = MMW_DW,
  parameter int                 NREG      = MMW_NREG,
  parameter logic [NREG*AW-1:0] REG_BASE  = MMW_DEF_BASE,
  parameter logic [NREG*AW-1:0] REG_LIMIT = MMW_DEF_LIMIT,
  parameter logic [NREG*4-1:0]  REG_WAIT  = MMW_DEF_WAIT,
  parameter logic [NREG-1:0]    REG_ACK   = MMW_DEF_ACK,
  parameter int                 TIMEOUT   = 64
) (
  input  logic            CLK,
  input  logic            RESETN,
  mem_mapper_ws_if.slave  bus
);

  localparam int IW = (NREG > 1) ? $clog2(NREG) : 1;
  localparam int WW = $clog2(TIMEOUT);

  mmw_state_e     state_q, state_d;
  logic [AW-1:0]  dev_addr_q, dev_addr_d;
  logic [IW-1:0]  idx_q, idx_d;
  logic [3:0]     cnt_q, cnt_d;
  logic [WW-1:0]  wdog_q, wdog_d;
  logic           ready_q, ready_d;
  logic [DW-1:0]  cpu_din_q, cpu_din_d;
  logic [NREG-1:0] sel_q, sel_d;
  logic           rd_dev_q, rd_dev_d;
  logic           wr_dev_q, wr_dev_d;
  logic [1:0]     be_q, be_d;
  logic           irq_q, irq_d;
  logic [AW-1:0]  fault_addr_q, fault_addr_d;

  logic            dec_hit_s;
  logic [IW-1:0]   dec_idx_s;
  logic [NREG-1:0] dec_onehot_s;
  logic            req_s;
  logic            perr_s;
  logic            err_entry_s;
  logic [AW-1:0]   err_addr_s;
  logic [DW-1:0]   din_sel_s;
  logic            done_ok_s;

  mem_mapper_ws_region_decoder #(
    .AW       (AW),
    .NREG     (NREG),
    .IW       (IW),
    .REG_BASE (REG_BASE),
    .REG_LIMIT(REG_LIMIT)
  ) u_dec (
    .addr_i  (bus.ADDR),
    .hit_o   (dec_hit_s),
    .idx_o   (dec_idx_s),
    .onehot_o(dec_onehot_s)
  );

  assign req_s     = mmw_req(bus.RDN, bus.WR0N, bus.WR1N);
  assign perr_s    = mmw_proto_err(bus.RDN, bus.WR0N, bus.WR1N);
  assign din_sel_s = bus.DIN_DEV[int'(idx_q)*DW +: DW];
  assign done_ok_s = (cnt_q == 4'd0) && (!REG_ACK[idx_q] || bus.DEV_ACK[idx_q]);

  // Next-state and next-output logic; outputs are registered alongside the state.
  always_comb begin
    state_d      = state_q;
    dev_addr_d   = dev_addr_q;
    idx_d        = idx_q;
    cnt_d        = cnt_q;
    wdog_d       = wdog_q;
    ready_d      = ready_q;
    cpu_din_d    = cpu_din_q;
    sel_d        = sel_q;
    rd_dev_d     = rd_dev_q;
    wr_dev_d     = wr_dev_q;
    be_d         = be_q;
    fault_addr_d = fault_addr_q;
    irq_d        = irq_q;
    err_entry_s  = 1'b0;
    err_addr_s   = dev_addr_q;

    case (state_q)
      MMW_IDLE: begin
        if (req_s) begin
          dev_addr_d = bus.ADDR;
          idx_d      = dec_idx_s;
          cnt_d      = REG_WAIT[int'(dec_idx_s)*4 +: 4];
          wdog_d     = '0;
          if (!dec_hit_s || perr_s) begin
            state_d     = MMW_ERR;
            ready_d     = 1'b1;
            cpu_din_d   = {DW{1'b1}};
            sel_d       = '0;
            rd_dev_d    = 1'b0;
            wr_dev_d    = 1'b0;
            be_d        = 2'b00;
            err_entry_s = 1'b1;
            err_addr_s  = bus.ADDR;
          end else begin
            state_d  = MMW_WAIT;
            sel_d    = dec_onehot_s;
            rd_dev_d = ~bus.RDN;
            wr_dev_d = bus.RDN;
            // Write lanes are crossed on purpose: BE[0] follows WR1N, BE[1] follows WR0N.
            be_d     = bus.RDN ? {~bus.WR0N, ~bus.WR1N} : 2'b11;
          end
        end else begin
          state_d = MMW_IDLE;
        end
      end
      MMW_WAIT: begin
        if (done_ok_s) begin
          state_d   = MMW_DONE;
          ready_d   = 1'b1;
          cpu_din_d = rd_dev_q ? din_sel_s : cpu_din_q;
        end else if (wdog_q == WW'(TIMEOUT - 1)) begin
          state_d     = MMW_ERR;
          ready_d     = 1'b1;
          cpu_din_d   = {DW{1'b1}};
          sel_d       = '0;
          rd_dev_d    = 1'b0;
          wr_dev_d    = 1'b0;
          be_d        = 2'b00;
          err_entry_s = 1'b1;
          err_addr_s  = dev_addr_q;
        end else begin
          cnt_d  = (cnt_q != 4'd0) ? cnt_q - 4'd1 : cnt_q;
          wdog_d = (wdog_q != {WW{1'b1}}) ? wdog_q + WW'(1) : wdog_q;
        end
      end
      MMW_DONE, MMW_ERR: begin
        if (!req_s) begin
          state_d  = MMW_IDLE;
          ready_d  = 1'b0;
          sel_d    = '0;
          rd_dev_d = 1'b0;
          wr_dev_d = 1'b0;
          be_d     = 2'b00;
        end else begin
          state_d = state_q;
        end
      end
      default: begin
        state_d  = MMW_IDLE;
        ready_d  = 1'b0;
        sel_d    = '0;
        rd_dev_d = 1'b0;
        wr_dev_d = 1'b0;
        be_d     = 2'b00;
      end
    endcase

    // A new fault outranks a simultaneous clear; only the first fault address is kept.
    if (err_entry_s) begin
      irq_d        = 1'b1;
      fault_addr_d = irq_q ? fault_addr_q : err_addr_s;
    end else if (bus.FAULT_CLR) begin
      irq_d = 1'b0;
    end else begin
      irq_d = irq_q;
    end
  end

  // State and registered-output flops.
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      state_q      <= MMW_IDLE;
      dev_addr_q   <= '0;
      idx_q        <= '0;
      cnt_q        <= 4'd0;
      wdog_q       <= '0;
      ready_q      <= 1'b0;
      cpu_din_q    <= '0;
      sel_q        <= '0;
      rd_dev_q     <= 1'b0;
      wr_dev_q     <= 1'b0;
      be_q         <= 2'b00;
      irq_q        <= 1'b0;
      fault_addr_q <= '0;
    end else begin
      state_q      <= state_d;
      dev_addr_q   <= dev_addr_d;
      idx_q        <= idx_d;
      cnt_q        <= cnt_d;
      wdog_q       <= wdog_d;
      ready_q      <= ready_d;
      cpu_din_q    <= cpu_din_d;
      sel_q        <= sel_d;
      rd_dev_q     <= rd_dev_d;
      wr_dev_q     <= wr_dev_d;
      be_q         <= be_d;
      irq_q        <= irq_d;
      fault_addr_q <= fault_addr_d;
    end
  end

  assign bus.CPU_DIN    = cpu_din_q;
  assign bus.READY      = ready_q;
  assign bus.SEL        = sel_q;
  assign bus.RD_DEV     = rd_dev_q;
  assign bus.WR_DEV     = wr_dev_q;
  assign bus.BE         = be_q;
  assign bus.DEV_ADDR   = dev_addr_q;
  assign bus.FAULT_IRQ  = irq_q;
  assign bus.FAULT_ADDR = fault_addr_q;

endmodule

// File: tb/tb_mem_mapper_ws.sv
// Scenario bench for mem_mapper_ws using the default region map; expected
// access results are queued when an access is launched and checked at READY.
module tb_mem_mapper_ws;

  logic CLK;
  logic RESETN;

  mem_mapper_ws_if #(.AW(16), .DW(16), .NREG(5)) bus ();

  mem_mapper_ws dut (
    .CLK   (CLK),
    .RESETN(RESETN),
    .bus   (bus.slave)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic [15:0] din;
    logic [4:0]  sel;
    logic [1:0]  be;
    int          lat;
  } exp_t;

  exp_t sb_q[$];
  int   tests_run = 0;
  int   fails     = 0;

  task automatic drive_req(input logic [15:0] a, input logic rdn, input logic w0, input logic w1);
    @(posedge CLK); #1;
    bus.ADDR = a; bus.RDN = rdn; bus.WR0N = w0; bus.WR1N = w1;
  endtask

  task automatic release_req();
    @(posedge CLK); #1;
    bus.RDN = 1'b1; bus.WR0N = 1'b1; bus.WR1N = 1'b1;
  endtask

  task automatic wait_ready(input int budget, output int n);
    n = -1;
    for (int k = 1; k <= budget; k++) begin
      @(posedge CLK); @(negedge CLK);
      if (bus.READY === 1'b1) begin n = k; break; end
    end
  endtask

  task automatic clear_fault();
    @(posedge CLK); #1 bus.FAULT_CLR = 1'b1;
    @(posedge CLK); #1 bus.FAULT_CLR = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    tests_run++;
    if ({bus.CPU_DIN, bus.READY, bus.SEL, bus.RD_DEV, bus.WR_DEV, bus.BE, bus.DEV_ADDR,
         bus.FAULT_IRQ, bus.FAULT_ADDR} !== '0) begin
      fails++; $display("FAIL reset_outputs: got nonzero outputs CPU_DIN=%h READY=%b SEL=%b", bus.CPU_DIN, bus.READY, bus.SEL);
    end
    repeat (2) @(posedge CLK);
    #1 RESETN = 1'b1;
  endtask

  task automatic test_rom_read();
    exp_t e; int n;
    bus.DIN_DEV[15:0] = 16'h1234;
    sb_q.push_back('{din: 16'h1234, sel: 5'b00001, be: 2'b11, lat: 1});
    drive_req(16'h0100, 1'b0, 1'b1, 1'b1);
    wait_ready(20, n);
    e = sb_q.pop_front();
    tests_run++; if (n - 1 != e.lat) begin fails++; $display("FAIL rom_latency: got %0d want %0d", n - 1, e.lat); end
    tests_run++; if (bus.CPU_DIN !== e.din) begin fails++; $display("FAIL rom_data: got %h want %h", bus.CPU_DIN, e.din); end
    tests_run++; if ({bus.SEL, bus.BE, bus.RD_DEV} !== {e.sel, e.be, 1'b1}) begin
      fails++; $display("FAIL rom_sel_be: got SEL=%b BE=%b RD=%b want %b %b 1", bus.SEL, bus.BE, bus.RD_DEV, e.sel, e.be);
    end
    tests_run++; if (bus.DEV_ADDR !== 16'h0100) begin fails++; $display("FAIL rom_dev_addr: got %h want 0100", bus.DEV_ADDR); end
    release_req();
    @(posedge CLK); @(negedge CLK);
    tests_run++; if ({bus.READY, bus.SEL, bus.BE} !== 8'h00) begin
      fails++; $display("FAIL rom_release: got READY=%b SEL=%b BE=%b want 0", bus.READY, bus.SEL, bus.BE);
    end
  endtask

  task automatic test_ram_write();
    exp_t e; int n;
    sb_q.push_back('{din: 16'h1234, sel: 5'b00010, be: 2'b10, lat: 3});
    drive_req(16'h2002, 1'b1, 1'b0, 1'b1);
    @(posedge CLK); @(negedge CLK);
    tests_run++; if ({bus.READY, bus.WR_DEV, bus.RD_DEV, bus.SEL, bus.BE} !== {1'b0, 1'b1, 1'b0, 5'b00010, 2'b10}) begin
      fails++; $display("FAIL ram_wait_outputs: got READY=%b WR=%b RD=%b SEL=%b BE=%b", bus.READY, bus.WR_DEV, bus.RD_DEV, bus.SEL, bus.BE);
    end
    bus.ADDR = 16'h0000;
    wait_ready(20, n);
    e = sb_q.pop_front();
    tests_run++; if (n != e.lat) begin fails++; $display("FAIL ram_latency: got %0d want %0d", n, e.lat); end
    repeat (3) @(negedge CLK);
    tests_run++; if ({bus.READY, bus.SEL, bus.BE, bus.CPU_DIN} !== {1'b1, e.sel, e.be, e.din}) begin
      fails++; $display("FAIL ram_hold: got READY=%b SEL=%b BE=%b DIN=%h", bus.READY, bus.SEL, bus.BE, bus.CPU_DIN);
    end
    tests_run++; if (bus.DEV_ADDR !== 16'h2002) begin fails++; $display("FAIL ram_dev_addr: got %h want 2002", bus.DEV_ADDR); end
    release_req();
    @(posedge CLK); @(negedge CLK);
    tests_run++; if ({bus.READY, bus.SEL, bus.WR_DEV} !== 7'h00) begin
      fails++; $display("FAIL ram_release: got READY=%b SEL=%b WR=%b want 0", bus.READY, bus.SEL, bus.WR_DEV);
    end
  endtask

  task automatic test_timeout();
    exp_t e; int n;
    bus.DEV_ACK = 5'b00000;
    bus.DIN_DEV[47:32] = 16'hABCD;
    sb_q.push_back('{din: 16'hFFFF, sel: 5'b00000, be: 2'b00, lat: 64});
    drive_req(16'hFFE0, 1'b0, 1'b1, 1'b1);
    wait_ready(200, n);
    e = sb_q.pop_front();
    tests_run++; if (n - 1 != e.lat) begin fails++; $display("FAIL timeout_latency: got %0d want %0d", n - 1, e.lat); end
    tests_run++; if ({bus.CPU_DIN, bus.SEL, bus.RD_DEV} !== {e.din, e.sel, 1'b0}) begin
      fails++; $display("FAIL timeout_err_outputs: got DIN=%h SEL=%b RD=%b", bus.CPU_DIN, bus.SEL, bus.RD_DEV);
    end
    tests_run++; if ({bus.FAULT_IRQ, bus.FAULT_ADDR} !== {1'b1, 16'hFFE0}) begin
      fails++; $display("FAIL timeout_fault: got IRQ=%b ADDR=%h want 1 FFE0", bus.FAULT_IRQ, bus.FAULT_ADDR);
    end
    release_req();
    clear_fault();
    @(negedge CLK);
    tests_run++; if (bus.FAULT_IRQ !== 1'b0) begin fails++; $display("FAIL fault_clear: got %b want 0", bus.FAULT_IRQ); end
  endtask

  task automatic test_ack();
    exp_t e; int n; logic early;
    early = 1'b0;
    sb_q.push_back('{din: 16'hABCD, sel: 5'b00100, be: 2'b11, lat: 4});
    drive_req(16'hFFE4, 1'b0, 1'b1, 1'b1);
    for (int k = 0; k < 4; k++) begin
      @(posedge CLK); @(negedge CLK);
      early = early | bus.READY;
    end
    bus.DEV_ACK = 5'b00100;
    wait_ready(20, n);
    e = sb_q.pop_front();
    bus.DEV_ACK = 5'b00000;
    tests_run++; if (early !== 1'b0 || n + 3 != e.lat) begin
      fails++; $display("FAIL ack_latency: got early=%b lat=%0d want 0 %0d", early, n + 3, e.lat);
    end
    tests_run++; if ({bus.CPU_DIN, bus.SEL, bus.BE} !== {e.din, e.sel, e.be}) begin
      fails++; $display("FAIL ack_data: got DIN=%h SEL=%b BE=%b", bus.CPU_DIN, bus.SEL, bus.BE);
    end
    release_req();
  endtask

  task automatic test_fault_sticky();
    exp_t e; int n;
    sb_q.push_back('{din: 16'hFFFF, sel: 5'b00000, be: 2'b00, lat: 0});
    drive_req(16'h8000, 1'b0, 1'b1, 1'b1);
    wait_ready(20, n);
    e = sb_q.pop_front();
    tests_run++; if (n - 1 != e.lat || bus.CPU_DIN !== e.din || bus.SEL !== e.sel) begin
      fails++; $display("FAIL unmapped_err: got lat=%0d DIN=%h SEL=%b", n - 1, bus.CPU_DIN, bus.SEL);
    end
    tests_run++; if ({bus.FAULT_IRQ, bus.FAULT_ADDR} !== {1'b1, 16'h8000}) begin
      fails++; $display("FAIL first_fault: got IRQ=%b ADDR=%h want 1 8000", bus.FAULT_IRQ, bus.FAULT_ADDR);
    end
    release_req();
    drive_req(16'h9000, 1'b0, 1'b1, 1'b1);
    wait_ready(20, n);
    tests_run++; if ({bus.FAULT_IRQ, bus.FAULT_ADDR} !== {1'b1, 16'h8000}) begin
      fails++; $display("FAIL second_fault_kept: got IRQ=%b ADDR=%h want 1 8000", bus.FAULT_IRQ, bus.FAULT_ADDR);
    end
    release_req();
    drive_req(16'hA000, 1'b0, 1'b1, 1'b1);
    bus.FAULT_CLR = 1'b1;
    @(posedge CLK); #1 bus.FAULT_CLR = 1'b0;
    @(negedge CLK);
    tests_run++; if ({bus.READY, bus.FAULT_IRQ, bus.FAULT_ADDR} !== {1'b1, 1'b1, 16'h8000}) begin
      fails++; $display("FAIL set_beats_clear: got READY=%b IRQ=%b ADDR=%h want 1 1 8000", bus.READY, bus.FAULT_IRQ, bus.FAULT_ADDR);
    end
    release_req();
    clear_fault();
  endtask

  task automatic test_proto_err();
    int n;
    drive_req(16'h2000, 1'b0, 1'b0, 1'b1);
    wait_ready(20, n);
    tests_run++; if (n != 1 || {bus.SEL, bus.RD_DEV, bus.WR_DEV, bus.CPU_DIN} !== {5'b0, 1'b0, 1'b0, 16'hFFFF}) begin
      fails++; $display("FAIL proto_err: got n=%0d SEL=%b RD=%b WR=%b DIN=%h", n, bus.SEL, bus.RD_DEV, bus.WR_DEV, bus.CPU_DIN);
    end
    tests_run++; if ({bus.FAULT_IRQ, bus.FAULT_ADDR} !== {1'b1, 16'h2000}) begin
      fails++; $display("FAIL proto_fault: got IRQ=%b ADDR=%h want 1 2000", bus.FAULT_IRQ, bus.FAULT_ADDR);
    end
    release_req();
  endtask

  task automatic test_reset_mid();
    exp_t e; int n;
    drive_req(16'hFFE8, 1'b0, 1'b1, 1'b1);
    repeat (2) @(posedge CLK);
    #1 RESETN = 1'b0;
    #1;
    tests_run++; if ({bus.CPU_DIN, bus.READY, bus.SEL, bus.RD_DEV, bus.WR_DEV, bus.BE, bus.DEV_ADDR,
                      bus.FAULT_IRQ, bus.FAULT_ADDR} !== '0) begin
      fails++; $display("FAIL reset_mid: got READY=%b SEL=%b IRQ=%b DEV_ADDR=%h want all 0", bus.READY, bus.SEL, bus.FAULT_IRQ, bus.DEV_ADDR);
    end
    bus.RDN = 1'b1;
    @(posedge CLK); #1 RESETN = 1'b1;
    @(posedge CLK); @(negedge CLK);
    tests_run++; if (bus.READY !== 1'b0) begin fails++; $display("FAIL reset_no_ready: got %b want 0", bus.READY); end
    bus.DIN_DEV[79:64] = 16'h5A5A;
    sb_q.push_back('{din: 16'h5A5A, sel: 5'b10000, be: 2'b11, lat: 2});
    drive_req(16'hFFF2, 1'b0, 1'b1, 1'b1);
    wait_ready(20, n);
    e = sb_q.pop_front();
    tests_run++; if (n - 1 != e.lat || {bus.CPU_DIN, bus.SEL, bus.BE} !== {e.din, e.sel, e.be}) begin
      fails++; $display("FAIL post_reset_access: got lat=%0d DIN=%h SEL=%b BE=%b want %0d %h %b %b",
                        n - 1, bus.CPU_DIN, bus.SEL, bus.BE, e.lat, e.din, e.sel, e.be);
    end
    release_req();
  endtask

  initial begin
    RESETN        = 1'b0;
    bus.ADDR      = 16'h0000;
    bus.RDN       = 1'b1;
    bus.WR0N      = 1'b1;
    bus.WR1N      = 1'b1;
    bus.DIN_DEV   = '0;
    bus.DIN_BUS   = 16'h0000;
    bus.DEV_ACK   = 5'b00000;
    bus.FAULT_CLR = 1'b0;
    test_reset();
    test_rom_read();
    test_ram_write();
    test_timeout();
    test_ack();
    test_fault_sticky();
    test_proto_err();
    test_reset_mid();
    repeat (2) @(posedge CLK);
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
